// File: rtl/market_pkg.sv
// Shared types and LFSR helper for the multi-channel market data generator.
package market_pkg;

    // Per-tick channel behaviour; encoding 2'd3 is reserved and treated as HOLD.
    typedef enum logic [1:0] {
        WALK = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } mode_e;

    // Output sequencer states: waiting for a tick, or streaming one burst.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Feedback taps at bits 31, 21, 1 and 0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One Fibonacci step: shift left, feedback parity enters at bit 0.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/price_walker.sv
// One price channel: owns its LFSR and price register, updated only on upd_i.
module price_walker
    import market_pkg::*;
#(
    parameter int          PRICE_W    = 16,
    parameter int          MAX_STEP   = 7,
    parameter int          PRICE_MIN  = 100,
    parameter int          PRICE_MAX  = 60000,
    parameter int          PRICE_INIT = 1000,
    parameter logic [31:0] LFSR_INIT  = 32'hABCDE123
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd_i,
    input  logic [1:0]         mode_i,
    output logic [PRICE_W-1:0] price_o
);

    // Two guard bits so a negative step or an overshoot is visible before clamping.
    localparam int SUM_W = PRICE_W + 2;

    logic [31:0]             lfsr_q, lfsr_d;
    logic [PRICE_W-1:0]      price_q, price_d;
    logic [3:0]              mag;
    logic signed [SUM_W-1:0] walk_sum;
    logic [SUM_W-1:0]        ramp_sum;

    // Next price and LFSR for whichever mode is active on this tick.
    always_comb begin
        mag      = 4'(32'(lfsr_q[3:0]) % 32'(MAX_STEP + 1));
        walk_sum = $signed({2'b00, price_q})
                 + (lfsr_q[0] ? $signed(SUM_W'(mag)) : -$signed(SUM_W'(mag)));
        ramp_sum = {2'b00, price_q} + SUM_W'(MAX_STEP);
        price_d  = price_q;
        lfsr_d   = lfsr_q;
        case (mode_i)
            WALK: begin
                lfsr_d = lfsr_next(lfsr_q);
                if (walk_sum < $signed(SUM_W'(PRICE_MIN)))
                    price_d = PRICE_W'(PRICE_MIN);
                else if (walk_sum > $signed(SUM_W'(PRICE_MAX)))
                    price_d = PRICE_W'(PRICE_MAX);
                else
                    price_d = walk_sum[PRICE_W-1:0];
            end
            RAMP: begin
                if (ramp_sum > SUM_W'(PRICE_MAX))
                    price_d = PRICE_W'(PRICE_MIN);
                else
                    price_d = ramp_sum[PRICE_W-1:0];
            end
            default: ;
        endcase
    end

    // Channel state only moves on an accepted market tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_INIT;
            price_q <= PRICE_W'(PRICE_INIT);
        end else if (upd_i) begin
            lfsr_q  <= lfsr_d;
            price_q <= price_d;
        end
    end

    assign price_o = price_q;

endmodule

// File: rtl/market_gen_mc.sv
// Multi-channel synthetic market source: tick divider, channel bank, burst streamer.
module market_gen_mc
    import market_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          PRICE_W    = 16,
    parameter int          CLK_DIV    = 100000,
    parameter int          MAX_STEP   = 7,
    parameter int          PRICE_MIN  = 100,
    parameter int          PRICE_MAX  = 60000,
    parameter int          PRICE_INIT = 1000,
    parameter logic [31:0] SEED       = 32'hABCDE123,
    localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    input  logic [1:0]         mode_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [CH_W-1:0]    ch_id_o,
    output logic [PRICE_W-1:0] price_o,
    output logic [15:0]        seq_o,
    output logic [15:0]        drop_cnt_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        drop_q, drop_d;
    logic               tick, upd;
    state_e             state_q;
    logic               valid_q;
    logic [CH_W-1:0]    ch_q, ch_nxt;
    logic [PRICE_W-1:0] price_q;
    logic [15:0]        seq_q;
    logic [PRICE_W-1:0] ch_price [NUM_CH];

    assign tick   = enable_i && (cnt_q == CNT_W'(CLK_DIV - 1));
    // Channels only move when no burst is outstanding, so a burst is a consistent snapshot.
    assign upd    = tick && (state_q == IDLE);
    assign ch_nxt = ch_q + CH_W'(1);

    // Tick divider next state and saturating count of ticks lost to an outstanding burst.
    always_comb begin
        cnt_d = cnt_q;
        if (enable_i)
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        drop_d = drop_q;
        if (tick && (state_q == DRAIN) && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;
    end

    // Divider and drop counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            drop_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            price_walker #(
                .PRICE_W   (PRICE_W),
                .MAX_STEP  (MAX_STEP),
                .PRICE_MIN (PRICE_MIN),
                .PRICE_MAX (PRICE_MAX),
                .PRICE_INIT(PRICE_INIT),
                .LFSR_INIT (SEED ^ (32'(gi) << 8))
            ) u_walker (
                .clk    (clk),
                .rst_n  (rst_n),
                .upd_i  (upd),
                .mode_i (mode_i),
                .price_o(ch_price[gi])
            );
        end
    endgenerate

    // Burst streamer: one idle beat after the tick, then channel 0..NUM_CH-1, one per accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ch_q    <= '0;
            price_q <= '0;
            seq_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        ch_q    <= '0;
                        price_q <= ch_price[0];
                    end else if (ready_i) begin
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
                            valid_q <= 1'b0;
                            seq_q   <= seq_q + 16'd1;
                            state_q <= IDLE;
                        end else begin
                            ch_q    <= ch_nxt;
                            price_q <= ch_price[ch_nxt];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o    = valid_q;
    assign ch_id_o    = ch_q;
    assign price_o    = price_q;
    assign seq_o      = seq_q;
    assign drop_cnt_o = drop_q;
    assign busy_o     = (state_q == DRAIN);

endmodule

// File: tb/tb_market_gen_mc.sv
// Randomized bench for market_gen_mc with a transaction-level reference model.
module tb_market_gen_mc;

    localparam int NUM_CH     = 2;
    localparam int R_CH       = 3;
    localparam int CLK_DIV    = 8;
    localparam int MAX_STEP   = 7;
    localparam int PRICE_MIN  = 100;
    localparam int PRICE_MAX  = 60000;
    localparam int PRICE_INIT = 1000;
    localparam int R_INIT     = 59995;
    localparam int unsigned SEED = 32'hABCDE123;
    localparam logic [1:0] M_WALK = 2'd0, M_RAMP = 2'd1, M_HOLD = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n, enable, ready;
    logic [1:0]  mode;
    logic        valid, busy;
    logic [0:0]  ch_id;
    logic [15:0] price, seq, drop_cnt;
    logic        r_valid, r_busy;
    logic [1:0]  r_ch;
    logic [15:0] r_price, r_seq, r_drop;

    always #5 clk = ~clk;

    market_gen_mc #(
        .NUM_CH(NUM_CH), .PRICE_W(16), .CLK_DIV(CLK_DIV), .MAX_STEP(MAX_STEP),
        .PRICE_MIN(PRICE_MIN), .PRICE_MAX(PRICE_MAX), .PRICE_INIT(PRICE_INIT), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .mode_i(mode), .ready_i(ready),
        .valid_o(valid), .ch_id_o(ch_id), .price_o(price), .seq_o(seq),
        .drop_cnt_o(drop_cnt), .busy_o(busy)
    );

    market_gen_mc #(
        .NUM_CH(R_CH), .PRICE_W(16), .CLK_DIV(CLK_DIV), .MAX_STEP(MAX_STEP),
        .PRICE_MIN(PRICE_MIN), .PRICE_MAX(PRICE_MAX), .PRICE_INIT(R_INIT), .SEED(SEED)
    ) dut_r (
        .clk(clk), .rst_n(rst_n), .enable_i(1'b1), .mode_i(M_RAMP), .ready_i(1'b1),
        .valid_o(r_valid), .ch_id_o(r_ch), .price_o(r_price), .seq_o(r_seq),
        .drop_cnt_o(r_drop), .busy_o(r_busy)
    );

    typedef struct { int ch; int price; int seq; } beat_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    beat_t       exp_q[$];
    int          mp[NUM_CH];
    int unsigned ml[NUM_CH];
    int          mcnt, mticks, mseq, mdrop;
    bit          mvalid, mpend, active;
    int          r_idx, r_burst, r_cur;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned lfsr_adv(input int unsigned s);
        int unsigned fb;
        fb = ((s >> 31) ^ (s >> 21) ^ (s >> 1) ^ s) & 32'd1;
        return (s << 1) | fb;
    endfunction

    function automatic int ramp_nx(input int p);
        return (p + MAX_STEP > PRICE_MAX) ? PRICE_MIN : p + MAX_STEP;
    endfunction

    task automatic model_reset();
        mcnt = 0; mticks = 0; mseq = 0; mdrop = 0;
        mvalid = 0; mpend = 0; active = 0;
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            mp[c] = PRICE_INIT;
            ml[c] = SEED ^ (c << 8);
        end
        r_idx = 0; r_burst = 0; r_cur = ramp_nx(R_INIT);
    endtask

    // Apply the channel rules for one accepted tick and queue the burst it produces.
    task automatic model_tick(input logic [1:0] m);
        int mag, np;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m == M_WALK) begin
                mag = int'(ml[c] & 15) % (MAX_STEP + 1);
                np  = mp[c] + (((ml[c] & 1) != 0) ? mag : -mag);
                if (np < PRICE_MIN) np = PRICE_MIN;
                if (np > PRICE_MAX) np = PRICE_MAX;
                mp[c] = np;
                ml[c] = lfsr_adv(ml[c]);
            end else if (m == M_RAMP) begin
                mp[c] = ramp_nx(mp[c]);
            end
        end
        for (int c = 0; c < NUM_CH; c++)
            exp_q.push_back('{ch: c, price: mp[c], seq: mseq});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_ch"}, ch_id, 0);
        check({tag, "_price"}, price, 0);
        check({tag, "_seq"}, seq, 0);
        check({tag, "_drop"}, drop_cnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rvalid"}, r_valid, 0);
    endtask

    // One clock: advance the model across the edge, then compare the settled outputs.
    task automatic cycle();
        bit tick, old_active;
        @(posedge clk);
        tick = enable && (mcnt == CLK_DIV - 1);
        if (enable) mcnt = tick ? 0 : mcnt + 1;
        if (tick) mticks++;
        old_active = active;
        if (mvalid && ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                mvalid = 0;
                mseq   = (mseq + 1) & 16'hFFFF;
                active = 0;
            end
        end else if (mpend) begin
            mvalid = 1;
            mpend  = 0;
        end
        if (tick) begin
            if (old_active) begin
                if (mdrop < 65535) mdrop++;
            end else begin
                model_tick(mode);
                active = 1;
                mpend  = 1;
            end
        end
        #1;
        check("valid", valid, mvalid);
        check("busy", busy, active);
        check("drop", drop_cnt, mdrop);
        if (mvalid && exp_q.size() > 0) begin
            check("beat_ch", ch_id, exp_q[0].ch);
            check("beat_price", price, exp_q[0].price);
            check("beat_seq", seq, exp_q[0].seq);
            check("bound", (price >= PRICE_MIN) && (price <= PRICE_MAX), 1);
        end
        if (r_valid) begin
            check("ramp_ch", r_ch, r_idx);
            check("ramp_price", r_price, r_cur);
            check("ramp_seq", r_seq, r_burst);
            r_idx++;
            if (r_idx == R_CH) begin
                r_idx = 0;
                r_burst++;
                r_cur = ramp_nx(r_cur);
            end
        end
    endtask

    initial begin
        int waited;
        rst_n = 1'b1; enable = 1'b0; ready = 1'b0; mode = M_WALK;
        #2 rst_n = 1'b0;
        #1 check_reset("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Walk with free-flowing output
        enable = 1'b1; ready = 1'b1; mode = M_WALK;
        repeat (20 * CLK_DIV) cycle();

        // Backpressure window, then release
        ready = 1'b0;
        repeat (40) cycle();
        ready = 1'b1;
        repeat (5 * CLK_DIV) cycle();

        // HOLD, then divider frozen
        mode = M_HOLD;
        repeat (10 * CLK_DIV) cycle();
        enable = 1'b0;
        repeat (10 * CLK_DIV) cycle();
        enable = 1'b1;
        mode = M_RAMP;
        repeat (5 * CLK_DIV) cycle();

        // Long randomized run: random ready, mode and occasional enable gaps
        for (int i = 0; i < 2000 * CLK_DIV; i++) begin
            ready  = ($urandom_range(0, 9) < 7);
            mode   = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 19) != 0);
            cycle();
        end

        // Drain and check tick accounting
        ready = 1'b1; enable = 1'b0;
        waited = 0;
        while (active && waited < 50) begin
            cycle();
            waited++;
        end
        check("drain_timeout", active, 0);
        check("seq_plus_drop", 32'(seq) + 32'(drop_cnt), mticks);

        // Abort a burst with an asynchronous reset
        enable = 1'b1; ready = 1'b0; mode = M_WALK;
        waited = 0;
        while (!mvalid && waited < 40) begin
            cycle();
            waited++;
        end
        check("burst_seen", valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset("mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Prices must be back at their reset value
        mode = M_HOLD; ready = 1'b1; enable = 1'b1;
        repeat (3 * CLK_DIV) cycle();
        check("ramp_drop", r_drop, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
